// File: rtl/pf_ddr3_dly_ctrl_pkg.sv
// Shared encodings for the DDR3 address/bank IOD delay-line sequencer.
// Optional feature macro: PF_DDR3_DLY_CTRL_TAP_READBACK_EN (used by the top).
package pf_ddr3_dly_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_ILL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK  = 2'b00,
      ST_OOR = 2'b01,
      ST_BAD = 2'b10
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_PULSE  = 3'd2,
      S_LOAD_P = 3'd3,
      S_GAP    = 3'd4,
      S_RSP    = 3'd5
   } state_e;

endpackage

// File: rtl/pf_ddr3_dly_tap_tracker.sv
// Per-lane saturating tap-position estimate, following the MOVE/LOAD strobes
// issued to the IOD delay lines. Only instantiated when
// PF_DDR3_DLY_CTRL_TAP_READBACK_EN is defined.
module pf_ddr3_dly_tap_tracker #(
   parameter int NUM_LANES = 3,
   parameter int TAP_W     = 8,
   parameter int TAP_RESET = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_LANES-1:0]       move,
   input  logic [NUM_LANES-1:0]       direction,
   input  logic [NUM_LANES-1:0]       load,
   output logic [NUM_LANES*TAP_W-1:0] tap_pos
);

   logic [TAP_W-1:0] tap [NUM_LANES];

   // One saturating up/down counter per lane; LOAD returns to the static delay value.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (rst || load[i]) begin
            tap[i] <= TAP_W'(TAP_RESET);
         end else if (move[i]) begin
            if (direction[i] && (tap[i] != {TAP_W{1'b1}})) begin
               tap[i] <= tap[i] + TAP_W'(1);
            end else if (!direction[i] && (tap[i] != '0)) begin
               tap[i] <= tap[i] - TAP_W'(1);
            end
         end
      end
   end

   // Flatten the lane counters onto the packed output bus.
   always_comb begin
      tap_pos = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         tap_pos[i*TAP_W +: TAP_W] = tap[i];
      end
   end

endmodule

// File: rtl/pf_ddr3_addr_dly_ctrl.sv
// Command-driven sequencer for the DDR3 address/bank IOD dynamic delay lines.
// One command at a time: inc/dec issues spaced MOVE pulses with a range check
// after each settle gap, load issues a single LOAD pulse; one response each.
// Optional feature macro: PF_DDR3_DLY_CTRL_TAP_READBACK_EN enables TAP_POS.
//
// state    | meaning
// IDLE     | CMD_READY high, waiting for a command
// CHECK    | decode latched command; DIRECTION already loaded at accept, so
//          | this cycle also serves as the direction settle cycle
// PULSE    | MOVE high on the selected lane for one cycle
// LOAD_P   | LOAD high on the selected lane for one cycle
// GAP      | settle GAP_CYCLES cycles, decide on the last one
// RSP      | RSP_VALID high for one cycle
module pf_ddr3_addr_dly_ctrl
   import pf_ddr3_dly_ctrl_pkg::*;
#(
   parameter int NUM_LANES  = 3,
   parameter int LANE_W     = 2,
   parameter int STEP_W     = 8,
   parameter int GAP_CYCLES = 4,
   parameter int TAP_W      = 8,
   parameter int TAP_RESET  = 1
) (
   input  logic                       FAB_CLK,
   input  logic                       SYNC_RST,
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic [1:0]                 CMD_OP,
   input  logic [LANE_W-1:0]          CMD_LANE,
   input  logic [STEP_W-1:0]          CMD_STEPS,
   output logic                       RSP_VALID,
   output logic [1:0]                 RSP_STATUS,
   output logic [STEP_W-1:0]          RSP_STEPS_DONE,
   output logic                       BUSY,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
   output logic [NUM_LANES*TAP_W-1:0] TAP_POS
);

   localparam int GAP_W = $clog2(GAP_CYCLES);

   state_e              state;
   op_e                 op_q;
   logic [LANE_W-1:0]   lane_q;
   logic [STEP_W-1:0]   steps_rem;
   logic [STEP_W-1:0]   steps_done;
   logic [GAP_W-1:0]    gap_cnt;
   logic                ready_r;
   logic                busy_r;
   logic                rsp_valid_r;
   status_e             rsp_status_r;
   logic [STEP_W-1:0]   rsp_steps_r;
   logic [NUM_LANES-1:0] move_r;
   logic [NUM_LANES-1:0] load_r;
   logic [NUM_LANES-1:0] dir_r;
   logic [NUM_LANES-1:0] oor_q;
   logic [NUM_LANES-1:0] lane_oh;
   logic [NUM_LANES-1:0] cmd_oh;
   logic                 oor_hit;

   // One-hot decode of the latched and incoming lane; out-of-range lanes decode to zero.
   always_comb begin
      lane_oh = '0;
      cmd_oh  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_oh[i] = (lane_q == LANE_W'(i));
         cmd_oh[i]  = (CMD_LANE == LANE_W'(i));
      end
   end

   // Range flags come from the IOD clock tree; register once before use.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) oor_q <= '0;
      else          oor_q <= DELAY_LINE_OUT_OF_RANGE;
   end

   assign oor_hit = |(oor_q & lane_oh);

   // Command sequencer with registered strobes and response fields.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state        <= S_IDLE;
         op_q         <= OP_INC;
         lane_q       <= '0;
         steps_rem    <= '0;
         steps_done   <= '0;
         gap_cnt      <= '0;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_status_r <= ST_OK;
         rsp_steps_r  <= '0;
         move_r       <= '0;
         load_r       <= '0;
         dir_r        <= '0;
      end else begin
         move_r      <= '0;
         load_r      <= '0;
         rsp_valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (CMD_VALID) begin
                  op_q       <= op_e'(CMD_OP);
                  lane_q     <= CMD_LANE;
                  steps_rem  <= CMD_STEPS;
                  steps_done <= '0;
                  dir_r      <= (op_e'(CMD_OP) == OP_INC) ? cmd_oh : '0;
                  ready_r    <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ((op_q == OP_ILL) || (lane_oh == '0)) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_BAD;
                  rsp_steps_r  <= '0;
                  state        <= S_RSP;
               end else if (op_q == OP_LOAD) begin
                  load_r <= lane_oh;
                  state  <= S_LOAD_P;
               end else if (steps_rem == '0) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_OK;
                  rsp_steps_r  <= '0;
                  state        <= S_RSP;
               end else begin
                  move_r     <= lane_oh;
                  steps_rem  <= steps_rem - STEP_W'(1);
                  steps_done <= steps_done + STEP_W'(1);
                  state      <= S_PULSE;
               end
            end
            S_PULSE, S_LOAD_P: begin
               gap_cnt <= GAP_W'(GAP_CYCLES - 1);
               state   <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end else if (op_q == OP_LOAD) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_OK;
                  rsp_steps_r  <= '0;
                  state        <= S_RSP;
               end else if (oor_hit) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_OOR;
                  rsp_steps_r  <= steps_done;
                  state        <= S_RSP;
               end else if (steps_rem != '0) begin
                  move_r     <= lane_oh;
                  steps_rem  <= steps_rem - STEP_W'(1);
                  steps_done <= steps_done + STEP_W'(1);
                  state      <= S_PULSE;
               end else begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_OK;
                  rsp_steps_r  <= steps_done;
                  state        <= S_RSP;
               end
            end
            S_RSP: begin
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign CMD_READY            = ready_r;
   assign BUSY                 = busy_r;
   assign RSP_VALID            = rsp_valid_r;
   assign RSP_STATUS           = rsp_status_r;
   assign RSP_STEPS_DONE       = rsp_steps_r;
   assign DELAY_LINE_MOVE      = move_r;
   assign DELAY_LINE_LOAD      = load_r;
   assign DELAY_LINE_DIRECTION = dir_r;

   // A TAP_RESET wider than TAP_W would be silently truncated by the tracker.
   if (TAP_RESET >= (1 << TAP_W)) begin : g_tap_reset_truncated
   end

`ifdef PF_DDR3_DLY_CTRL_TAP_READBACK_EN
   pf_ddr3_dly_tap_tracker #(
      .NUM_LANES (NUM_LANES),
      .TAP_W     (TAP_W),
      .TAP_RESET (TAP_RESET)
   ) u_tap_tracker (
      .clk       (FAB_CLK),
      .rst       (SYNC_RST),
      .move      (move_r),
      .direction (dir_r),
      .load      (load_r),
      .tap_pos   (TAP_POS)
   );
`else
   assign TAP_POS = '0;
`endif

endmodule

// File: tb/tb_pf_ddr3_addr_dly_ctrl.sv
// Bench for pf_ddr3_addr_dly_ctrl: directed table, mid-command reset, then
// randomized commands checked against a rule-level model of the sequencer.
module tb_pf_ddr3_addr_dly_ctrl;

   localparam int NL   = 3;
   localparam int LW   = 2;
   localparam int SW   = 8;
   localparam int GAP  = 4;
   localparam int TW   = 8;
   localparam int TRST = 1;

   logic              FAB_CLK = 1'b0;
   logic              SYNC_RST;
   logic              CMD_VALID;
   logic              CMD_READY;
   logic [1:0]        CMD_OP;
   logic [LW-1:0]     CMD_LANE;
   logic [SW-1:0]     CMD_STEPS;
   logic              RSP_VALID;
   logic [1:0]        RSP_STATUS;
   logic [SW-1:0]     RSP_STEPS_DONE;
   logic              BUSY;
   logic [NL-1:0]     DELAY_LINE_MOVE;
   logic [NL-1:0]     DELAY_LINE_DIRECTION;
   logic [NL-1:0]     DELAY_LINE_LOAD;
   logic [NL-1:0]     DELAY_LINE_OUT_OF_RANGE;
   logic [NL*TW-1:0]  TAP_POS;

   always #5 FAB_CLK = ~FAB_CLK;

   pf_ddr3_addr_dly_ctrl #(
      .NUM_LANES(NL), .LANE_W(LW), .STEP_W(SW), .GAP_CYCLES(GAP), .TAP_W(TW), .TAP_RESET(TRST)
   ) dut (
      .FAB_CLK                 (FAB_CLK),
      .SYNC_RST                (SYNC_RST),
      .CMD_VALID               (CMD_VALID),
      .CMD_READY               (CMD_READY),
      .CMD_OP                  (CMD_OP),
      .CMD_LANE                (CMD_LANE),
      .CMD_STEPS               (CMD_STEPS),
      .RSP_VALID               (RSP_VALID),
      .RSP_STATUS              (RSP_STATUS),
      .RSP_STEPS_DONE          (RSP_STEPS_DONE),
      .BUSY                    (BUSY),
      .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
      .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
      .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
      .TAP_POS                 (TAP_POS)
   );

   int checks   = 0;
   int failures = 0;
   int tap_m [NL];

   typedef struct {
      int op;
      int lane;
      int steps;
      int oor_after;   // -1: target flag never rises; k: rises once k pulses were seen
      int st;
      int sd;
      int rc;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Rule-level expectation: status, steps issued, response cycle after accept.
   function automatic void model(input int op, input int lane, input int steps, input int oor_after,
                                 output int st, output int sd, output int rc);
      if (op == 3 || lane >= NL) begin
         st = 2; sd = 0; rc = 2;
      end else if (op == 2) begin
         st = 0; sd = 0; rc = 2 + (1 + GAP);
      end else if (steps == 0) begin
         st = 0; sd = 0; rc = 2;
      end else if (oor_after >= 0 && oor_after <= steps) begin
         st = 1; sd = (oor_after == 0) ? 1 : oor_after; rc = 2 + sd * (1 + GAP);
      end else begin
         st = 0; sd = steps; rc = 2 + steps * (1 + GAP);
      end
   endfunction

   task automatic check_taps(input string tag);
      for (int i = 0; i < NL; i++) begin
`ifdef PF_DDR3_DLY_CTRL_TAP_READBACK_EN
         chk($sformatf("%s tap%0d", tag, i), 64'(TAP_POS[i*TW +: TW]), 64'(tap_m[i]));
`else
         chk($sformatf("%s tap%0d", tag, i), 64'(TAP_POS[i*TW +: TW]), 64'd0);
`endif
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      int            cyc;
      int            npulse;
      int            nload;
      int            rsp_cyc;
      int            st_act;
      int            sd_act;
      logic          got;
      logic          move_ok;
      logic          load_ok;
      logic [NL-1:0] oh;
      logic [NL-1:0] noise;
      logic [NL-1:0] dir_exp;
      oh      = (v.lane < NL) ? NL'(1 << v.lane) : '0;
      noise   = NL'($urandom) & ~oh;
      dir_exp = (v.op == 0) ? oh : '0;
      @(negedge FAB_CLK);
      CMD_VALID = 1'b1;
      CMD_OP    = 2'(v.op);
      CMD_LANE  = LW'(v.lane);
      CMD_STEPS = SW'(v.steps);
      DELAY_LINE_OUT_OF_RANGE = noise | ((v.oor_after == 0) ? oh : '0);
      chk({tag, " ready_idle"}, 64'(CMD_READY), 64'd1);
      @(negedge FAB_CLK);
      CMD_VALID = 1'b0;
      CMD_OP    = 2'($urandom);
      CMD_LANE  = LW'($urandom);
      CMD_STEPS = SW'($urandom);
      cyc = 1;
      chk({tag, " busy_c1"}, 64'(BUSY), 64'd1);
      chk({tag, " ready_c1"}, 64'(CMD_READY), 64'd0);
      chk({tag, " dir"}, 64'(DELAY_LINE_DIRECTION), 64'(dir_exp));
      got = 1'b0; npulse = 0; nload = 0; move_ok = 1'b1; load_ok = 1'b1;
      rsp_cyc = -1; st_act = -1; sd_act = -1;
      while (!got && cyc < 400) begin
         if (DELAY_LINE_MOVE != '0) begin
            if (DELAY_LINE_MOVE !== oh || cyc != 2 + npulse * (1 + GAP)) move_ok = 1'b0;
            npulse++;
            if (v.oor_after > 0 && npulse == v.oor_after) DELAY_LINE_OUT_OF_RANGE = DELAY_LINE_OUT_OF_RANGE | oh;
         end
         if (DELAY_LINE_LOAD != '0) begin
            if (DELAY_LINE_LOAD !== oh || cyc != 2) load_ok = 1'b0;
            nload++;
         end
         if (RSP_VALID === 1'b1) begin
            got = 1'b1; rsp_cyc = cyc; st_act = int'(RSP_STATUS); sd_act = int'(RSP_STEPS_DONE);
            chk({tag, " busy_rsp"}, 64'(BUSY), 64'd1);
         end else begin
            @(negedge FAB_CLK);
            cyc++;
         end
      end
      chk({tag, " rsp_seen"}, 64'(got), 64'd1);
      chk({tag, " rsp_cycle"}, 64'(rsp_cyc), 64'(v.rc));
      chk({tag, " status"}, 64'(st_act), 64'(v.st));
      chk({tag, " steps_done"}, 64'(sd_act), 64'(v.sd));
      chk({tag, " move_count"}, 64'(npulse), 64'((v.op < 2) ? v.sd : 0));
      chk({tag, " move_shape"}, 64'(move_ok), 64'd1);
      chk({tag, " load_count"}, 64'(nload), 64'((v.op == 2 && v.lane < NL) ? 1 : 0));
      chk({tag, " load_shape"}, 64'(load_ok), 64'd1);
      @(negedge FAB_CLK);
      DELAY_LINE_OUT_OF_RANGE = '0;
      chk({tag, " rsp_one_cycle"}, 64'(RSP_VALID), 64'd0);
      chk({tag, " ready_after"}, 64'(CMD_READY), 64'd1);
      chk({tag, " busy_after"}, 64'(BUSY), 64'd0);
      chk({tag, " status_hold"}, 64'(RSP_STATUS), 64'(v.st));
      chk({tag, " steps_hold"}, 64'(RSP_STEPS_DONE), 64'(v.sd));
      chk({tag, " dir_hold"}, 64'(DELAY_LINE_DIRECTION), 64'(dir_exp));
      if (v.lane < NL) begin
         if (v.op == 2) tap_m[v.lane] = TRST;
         if (v.op < 2) begin
            for (int k = 0; k < v.sd; k++) begin
               if (v.op == 0) tap_m[v.lane] = (tap_m[v.lane] < (1 << TW) - 1) ? tap_m[v.lane] + 1 : tap_m[v.lane];
               else           tap_m[v.lane] = (tap_m[v.lane] > 0) ? tap_m[v.lane] - 1 : 0;
            end
         end
      end
      check_taps(tag);
   endtask

   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int   errs;
      // op lane steps oor_after | status steps rsp_cycle
      tbl[0] = '{1, 0, 3, -1, 0, 3, 17};   // dec from reset value saturates at 0
      tbl[1] = '{0, 1, 3, -1, 0, 3, 17};   // pulses at 2,7,12
      tbl[2] = '{1, 0, 5,  2, 1, 2, 12};   // range flag after 2nd pulse
      tbl[3] = '{2, 2, 9,  0, 0, 0,  7};   // load, flag ignored
      tbl[4] = '{0, 3, 2, -1, 2, 0,  2};   // lane out of range
      tbl[5] = '{3, 0, 4, -1, 2, 0,  2};   // illegal op
      tbl[6] = '{0, 0, 0, -1, 0, 0,  2};   // zero steps
      tbl[7] = '{0, 2, 1,  0, 1, 1,  7};   // flag already high: one step then abort
      tbl[8] = '{0, 1, 2,  2, 1, 2, 12};   // flag rises after the last pulse

      SYNC_RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_LANE = '0; CMD_STEPS = '0;
      DELAY_LINE_OUT_OF_RANGE = '0;
      for (int i = 0; i < NL; i++) tap_m[i] = TRST;
      repeat (3) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
      chk("reset ready", 64'(CMD_READY), 64'd1);
      chk("reset busy", 64'(BUSY), 64'd0);
      chk("reset rsp_valid", 64'(RSP_VALID), 64'd0);
      chk("reset status", 64'(RSP_STATUS), 64'd0);
      chk("reset steps", 64'(RSP_STEPS_DONE), 64'd0);
      chk("reset move", 64'(DELAY_LINE_MOVE), 64'd0);
      chk("reset load", 64'(DELAY_LINE_LOAD), 64'd0);
      chk("reset dir", 64'(DELAY_LINE_DIRECTION), 64'd0);
      check_taps("reset");

      for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset landing in the first settle gap of a 4-step increment.
      @(negedge FAB_CLK);
      CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_LANE = LW'(1); CMD_STEPS = SW'(4);
      @(negedge FAB_CLK);
      CMD_VALID = 1'b0;
      repeat (3) @(negedge FAB_CLK);
      SYNC_RST = 1'b1;
      @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
      for (int i = 0; i < NL; i++) tap_m[i] = TRST;
      chk("midrst move", 64'(DELAY_LINE_MOVE), 64'd0);
      chk("midrst load", 64'(DELAY_LINE_LOAD), 64'd0);
      chk("midrst rsp_valid", 64'(RSP_VALID), 64'd0);
      chk("midrst ready", 64'(CMD_READY), 64'd1);
      chk("midrst busy", 64'(BUSY), 64'd0);
      chk("midrst dir", 64'(DELAY_LINE_DIRECTION), 64'd0);
      errs = 0;
      repeat (30) begin
         @(negedge FAB_CLK);
         if (RSP_VALID !== 1'b0 || DELAY_LINE_MOVE !== '0 || BUSY !== 1'b0) errs++;
      end
      chk("midrst quiet", 64'(errs), 64'd0);
      check_taps("midrst");
      v = '{0, 1, 2, -1, 0, 2, 12};
      apply(v, "post_rst");

      for (int n = 0; n < 40; n++) begin
         v.op        = int'($urandom_range(0, 3));
         v.lane      = int'($urandom_range(0, 3));
         v.steps     = int'($urandom_range(0, 6));
         v.oor_after = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, v.steps));
         model(v.op, v.lane, v.steps, v.oor_after, v.st, v.sd, v.rc);
         apply(v, $sformatf("rnd%0d op%0d ln%0d st%0d oa%0d", n, v.op, v.lane, v.steps, v.oor_after));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
